// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared definitions for the FIFO write arbiter
// Holds the FSM state encoding, the data-slice offset helper and the
// width helper used by the parameter legality checks.
package fifo_wr_arbiter_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester beats in, FIFO write port out
// Signals: req_valid/req_last/req_data/req_ready (per-requester handshake),
// fifo_full/fifo_wr_en/fifo_wr_data (FIFO write pins).
// master = requesters + FIFO side, slave = arbiter side.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   modport master (
      output req_valid, req_last, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_wr_data
   );
   modport slave (
      input  req_valid, req_last, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_wr_data
   );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// fifo_wr_arbiter_rr_pick: combinational round-robin picker
// Ports: req_i (request vector), last_idx_i (previous winner),
// pick_idx_o (first requester after last_idx_i, wrapping), pick_vld_o (any request).
module fifo_wr_arbiter_rr_pick #(
   parameter int NUM_REQ   = 4,
   parameter int IDX_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [IDX_WIDTH-1:0] last_idx_i,
   output logic [IDX_WIDTH-1:0] pick_idx_o,
   output logic                 pick_vld_o
);
   logic [IDX_WIDTH-1:0] j;
   // Scan from the farthest offset to the nearest so the nearest hit wins.
   always_comb begin
      pick_vld_o = 1'b0;
      pick_idx_o = '0;
      j = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = IDX_WIDTH'((int'(last_idx_i) + k) % NUM_REQ);
         if (req_i[j]) begin
            pick_vld_o = 1'b1;
            pick_idx_o = j;
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locking arbiter in front of a FIFO write port
// Ports: clk, rst_n (async active-low), bus (slave side of fifo_wr_arbiter_if),
// gnt (registered one-hot grant, zero when idle), busy (high while a grant is held).
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int IDX_WIDTH  = 2,
   parameter int CNT_WIDTH  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   fifo_wr_arbiter_if.slave   bus,
   output logic [NUM_REQ-1:0] gnt,
   output logic               busy
);
   if (NUM_REQ < 2 || MAX_BURST < 1 || IDX_WIDTH != $clog2(NUM_REQ) ||
       CNT_WIDTH != clog2_min1(MAX_BURST)) begin : g_bad_params
      $error("fifo_wr_arbiter: illegal parameter combination");
   end
   state_t               state_q, state_d;
   logic [IDX_WIDTH-1:0] own_q, own_d, last_q, last_d, pick_idx;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d, pick_req;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 pick_vld, xfer, rel;
   assign xfer = (state_q == ST_LOCKED) & bus.req_valid[own_q] & ~bus.fifo_full;
   assign rel  = xfer & (bus.req_last[own_q] | (cnt_q == CNT_WIDTH'(MAX_BURST - 1)));
   // The owner's valid on its last beat belongs to the beat being consumed, so it
   // is masked from the re-pick; after a forced release the owner stays eligible.
   assign pick_req = (state_q == ST_LOCKED) ?
                     bus.req_valid & ~(gnt_q & {NUM_REQ{bus.req_last[own_q]}}) :
                     bus.req_valid;
   // Re-pick on release starts at own+1, the IDLE pick at last_idx+1.
   fifo_wr_arbiter_rr_pick #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_pick (
      .req_i      (pick_req),
      .last_idx_i ((state_q == ST_LOCKED) ? own_q : last_q),
      .pick_idx_o (pick_idx),
      .pick_vld_o (pick_vld)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         own_q   <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         last_q  <= IDX_WIDTH'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end
   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      if (state_q == ST_IDLE) begin
         if (pick_vld) begin
            state_d = ST_LOCKED;
            own_d   = pick_idx;
            gnt_d   = NUM_REQ'(1) << pick_idx;
            cnt_d   = '0;
         end
      end else if (rel) begin
         last_d  = own_q;
         cnt_d   = '0;
         state_d = pick_vld ? ST_LOCKED : ST_IDLE;
         own_d   = pick_vld ? pick_idx : own_q;
         gnt_d   = pick_vld ? NUM_REQ'(1) << pick_idx : '0;
      end else if (xfer) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end
   always_comb begin
      busy             = state_q == ST_LOCKED;
      gnt              = gnt_q;
      bus.req_ready    = gnt_q & {NUM_REQ{busy & ~bus.fifo_full}};
      bus.fifo_wr_en   = xfer;
      bus.fifo_wr_data = busy ? bus.req_data[slice_lo(int'(own_q), DATA_WIDTH) +: DATA_WIDTH] : '0;
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
   logic            clk = 1'b0;
   logic            rst_n;
   logic [3:0]      v, l, gnt;
   logic [3:0][7:0] d;
   logic            full, busy;
   int              errors = 0;
   int              checks = 0;
   fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();
   assign bus.req_valid = v;
   assign bus.req_last  = l;
   assign bus.req_data  = d;
   assign bus.fifo_full = full;
   fifo_wr_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8),
      .MAX_BURST  (4),
      .IDX_WIDTH  (2),
      .CNT_WIDTH  (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .gnt   (gnt),
      .busy  (busy)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #2;
   endtask
   task automatic rst_pulse;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      rst_n = 1'b0;
      v = '0;
      l = '0;
      d = '0;
      full = 1'b0;
      #3;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_wen", 32'(bus.fifo_wr_en), 32'h0);
      chk("rst_wdata", 32'(bus.fifo_wr_data), 32'h0);
      #4 rst_n = 1'b1;
      // single requester, 3-beat packet
      tick;
      d[0] = 8'hA1;
      v = 4'b0001;
      #1;
      chk("t1_idle_wen", 32'(bus.fifo_wr_en), 32'h0);
      chk("t1_idle_gnt", 32'(gnt), 32'h0);
      tick;
      #1;
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_ready", 32'(bus.req_ready), 32'h1);
      chk("t1_b1_wen", 32'(bus.fifo_wr_en), 32'h1);
      chk("t1_b1_data", 32'(bus.fifo_wr_data), 32'hA1);
      tick;
      d[0] = 8'hA2;
      #1;
      chk("t1_b2_wen", 32'(bus.fifo_wr_en), 32'h1);
      chk("t1_b2_data", 32'(bus.fifo_wr_data), 32'hA2);
      tick;
      d[0] = 8'hA3;
      l = 4'b0001;
      #1;
      chk("t1_b3_wen", 32'(bus.fifo_wr_en), 32'h1);
      chk("t1_b3_data", 32'(bus.fifo_wr_data), 32'hA3);
      tick;
      v = '0;
      l = '0;
      #1;
      chk("t1_end_gnt", 32'(gnt), 32'h0);
      chk("t1_end_busy", 32'(busy), 32'h0);
      chk("t1_end_wen", 32'(bus.fifo_wr_en), 32'h0);
      // all requesters, single-beat packets
      rst_pulse;
      v = 4'b1111;
      l = 4'b1111;
      d = {8'h33, 8'h32, 8'h31, 8'h30};
      #1;
      chk("t2_idle_wen", 32'(bus.fifo_wr_en), 32'h0);
      for (int k = 0; k < 5; k++) begin
         tick;
         if (k == 4) v = 4'b0001;
         #1;
         chk("t2_gnt", 32'(gnt), 32'h1 << (k % 4));
         chk("t2_wen", 32'(bus.fifo_wr_en), 32'h1);
         chk("t2_data", 32'(bus.fifo_wr_data), 32'h30 + 32'(k % 4));
      end
      tick;
      v = '0;
      l = '0;
      #1;
      chk("t2_end_gnt", 32'(gnt), 32'h0);
      // burst cap: req1 streams, req2 waits
      rst_pulse;
      v = 4'b0110;
      l = 4'b0100;
      d[1] = 8'h01;
      d[2] = 8'hC0;
      #1;
      chk("t3_idle_wen", 32'(bus.fifo_wr_en), 32'h0);
      for (int b = 1; b <= 4; b++) begin
         tick;
         d[1] = 8'(b);
         #1;
         chk("t3_gnt1", 32'(gnt), 32'h2);
         chk("t3_data1", 32'(bus.fifo_wr_data), 32'(b));
      end
      tick;
      #1;
      chk("t3_gnt2", 32'(gnt), 32'h4);
      chk("t3_data2", 32'(bus.fifo_wr_data), 32'hC0);
      chk("t3_ready2", 32'(bus.req_ready), 32'h4);
      tick;
      v = 4'b0010;
      l = 4'b0000;
      d[1] = 8'h05;
      #1;
      chk("t3_resume_gnt", 32'(gnt), 32'h2);
      chk("t3_resume_data", 32'(bus.fifo_wr_data), 32'h05);
      for (int b = 6; b <= 9; b++) begin
         tick;
         d[1] = 8'(b);
         #1;
         chk("t3_gnt1b", 32'(gnt), 32'h2);
         chk("t3_wen1b", 32'(bus.fifo_wr_en), 32'h1);
         chk("t3_data1b", 32'(bus.fifo_wr_data), 32'(b));
      end
      tick;
      d[1] = 8'h0A;
      l = 4'b0010;
      #1;
      chk("t3_last_data", 32'(bus.fifo_wr_data), 32'h0A);
      tick;
      v = '0;
      l = '0;
      #1;
      chk("t3_end_busy", 32'(busy), 32'h0);
      // FIFO full stalls the owner mid-packet
      rst_pulse;
      v = 4'b1001;
      d[0] = 8'h41;
      d[3] = 8'hD3;
      #1;
      tick;
      #1;
      chk("t4_gnt", 32'(gnt), 32'h1);
      chk("t4_b1_data", 32'(bus.fifo_wr_data), 32'h41);
      tick;
      d[0] = 8'h42;
      #1;
      chk("t4_b2_wen", 32'(bus.fifo_wr_en), 32'h1);
      chk("t4_b2_data", 32'(bus.fifo_wr_data), 32'h42);
      for (int c = 0; c < 3; c++) begin
         tick;
         full = 1'b1;
         #1;
         chk("t4_full_wen", 32'(bus.fifo_wr_en), 32'h0);
         chk("t4_full_ready", 32'(bus.req_ready), 32'h0);
         chk("t4_full_gnt", 32'(gnt), 32'h1);
      end
      tick;
      full = 1'b0;
      d[0] = 8'h43;
      #1;
      chk("t4_b3_wen", 32'(bus.fifo_wr_en), 32'h1);
      chk("t4_b3_data", 32'(bus.fifo_wr_data), 32'h43);
      tick;
      d[0] = 8'h44;
      l = 4'b0001;
      #1;
      chk("t4_b4_gnt", 32'(gnt), 32'h1);
      chk("t4_b4_data", 32'(bus.fifo_wr_data), 32'h44);
      tick;
      v = 4'b1000;
      l = 4'b1000;
      #1;
      chk("t4_next_gnt", 32'(gnt), 32'h8);
      chk("t4_next_data", 32'(bus.fifo_wr_data), 32'hD3);
      tick;
      v = '0;
      l = '0;
      #1;
      chk("t4_end_busy", 32'(busy), 32'h0);
      // reset mid-burst
      v = 4'b0100;
      d[2] = 8'h51;
      #1;
      tick;
      #1;
      chk("t5_gnt", 32'(gnt), 32'h4);
      tick;
      d[2] = 8'h52;
      #1;
      chk("t5_wen", 32'(bus.fifo_wr_en), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_gnt", 32'(gnt), 32'h0);
      chk("t5_rst_wen", 32'(bus.fifo_wr_en), 32'h0);
      chk("t5_rst_busy", 32'(busy), 32'h0);
      v = 4'b1001;
      d[0] = 8'h61;
      d[3] = 8'h71;
      rst_n = 1'b1;
      #1;
      chk("t5_idle_wen", 32'(bus.fifo_wr_en), 32'h0);
      tick;
      l = 4'b0001;
      #1;
      chk("t5_gnt0", 32'(gnt), 32'h1);
      chk("t5_data0", 32'(bus.fifo_wr_data), 32'h61);
      tick;
      v = 4'b1000;
      l = 4'b1000;
      #1;
      chk("t5_gnt3", 32'(gnt), 32'h8);
      chk("t5_data3", 32'(bus.fifo_wr_data), 32'h71);
      tick;
      v = '0;
      l = '0;
      #1;
      chk("t5_end_busy", 32'(busy), 32'h0);
      // owner stalls its own packet; others must wait
      v = 4'b1010;
      d[1] = 8'h81;
      d[3] = 8'h91;
      #1;
      tick;
      #1;
      chk("t6_gnt", 32'(gnt), 32'h2);
      chk("t6_b1_data", 32'(bus.fifo_wr_data), 32'h81);
      for (int c = 0; c < 5; c++) begin
         tick;
         v = 4'b1000;
         #1;
         chk("t6_gap_wen", 32'(bus.fifo_wr_en), 32'h0);
         chk("t6_gap_gnt", 32'(gnt), 32'h2);
      end
      tick;
      v = 4'b1010;
      l = 4'b0010;
      d[1] = 8'h82;
      #1;
      chk("t6_b2_wen", 32'(bus.fifo_wr_en), 32'h1);
      chk("t6_b2_data", 32'(bus.fifo_wr_data), 32'h82);
      tick;
      v = 4'b1000;
      l = 4'b1000;
      #1;
      chk("t6_gnt3", 32'(gnt), 32'h8);
      chk("t6_data3", 32'(bus.fifo_wr_data), 32'h91);
      tick;
      v = '0;
      l = '0;
      #1;
      chk("t6_end_gnt", 32'(gnt), 32'h0);
      chk("t6_end_busy", 32'(busy), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
